ysyx_22041207_ifu: RTL and testbench

Instruction fetch unit directly upstream of the decoder. It owns the architectural PC, issues one 32-bit fetch at a time to instruction memory over a valid/ready request and valid response interface, and presents {inst, pc} to the decoder through a registered valid/ready output. Redirects from execute/writeback (jal, jalr, taken branch, ecall, mret) override sequential PC+4 and squash any in-flight fetch.

---
 rtl/ysyx_22041207_ifu_if.sv | 23 ++
 rtl/ysyx_22041207_ifu.sv | 103 ++++++++++
 tb/tb_ysyx_22041207_ifu.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ysyx_22041207_ifu_if.sv
// ysyx_22041207_ifu_if: redirect, instruction-memory and decoder-side signals of the fetch unit
interface ysyx_22041207_ifu_if #(parameter int PC_W = 64);
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [PC_W-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [PC_W-1:0] out_pc;
    logic            out_fault;
    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, out_fault
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, out_fault
    );
endinterface

// File: rtl/ysyx_22041207_ifu.sv
// ysyx_22041207_ifu: single-outstanding instruction fetch unit with redirect squash.
// IFU_MISALIGN_TRAP_EN: misaligned PC produces a faulting output instead of being force-aligned.
module ysyx_22041207_ifu #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input logic                  clk,
    input logic                  rst,
    ysyx_22041207_ifu_if.master  bus
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_e;
    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, out_pc_q, out_pc_d;
    logic [31:0]     out_inst_q, out_inst_d;
    logic            drop_q, drop_d, out_valid_q, out_valid_d, out_fault_q, out_fault_d;
    logic            misalign, req_valid;
    logic [PC_W-1:0] redirect_tgt;
`ifdef IFU_MISALIGN_TRAP_EN
    assign misalign     = pc_q[1:0] != 2'b00;
    assign redirect_tgt = bus.redirect_pc;
`else
    assign misalign     = 1'b0;
    assign redirect_tgt = bus.redirect_pc & ~PC_W'(3);
`endif
    assign req_valid          = state_q == REQ && !misalign;
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_inst       = out_inst_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_fault      = out_fault_q;
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_fault_d = out_fault_q;
        if (bus.redirect_valid) begin
            // an outstanding or just-accepted request must have its response swallowed
            pc_d        = redirect_tgt;
            out_valid_d = 1'b0;
            out_fault_d = 1'b0;
            state_d     = ((state_q == WAIT && !bus.imem_resp_valid) || (req_valid && bus.imem_req_ready)) ? WAIT : REQ;
            drop_d      = state_d == WAIT;
        end else begin
            case (state_q)
                REQ: begin
                    if (misalign) begin
                        out_valid_d = 1'b1;
                        out_fault_d = 1'b1;
                        out_inst_d  = 32'h0;
                        out_pc_d    = pc_q;
                        state_d     = HOLD;
                    end else if (bus.imem_req_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = drop_q ? REQ : HOLD;
                        if (!drop_q) begin
                            out_valid_d = 1'b1;
                            out_fault_d = 1'b0;
                            out_inst_d  = bus.imem_resp_data;
                            out_pc_d    = pc_q;
                            pc_d        = pc_q + PC_W'(4);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        out_fault_d = 1'b0;
                        state_d     = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0;
            out_pc_q    <= '0;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_fault_q <= out_fault_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
// tb_ysyx_22041207_ifu: random fetch/redirect/stall traffic against a flag-based fetch model
module tb_ysyx_22041207_ifu;
    localparam int W = 64;
    localparam logic [W-1:0] RST_PC = 64'h0000_0000_8000_0000;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    ysyx_22041207_ifu_if #(.PC_W(W)) bus();
    ysyx_22041207_ifu #(.PC_W(W), .RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_chk = 0, n_err = 0;
    logic [W-1:0] m_pc, m_opc, ma;
    logic [31:0]  m_oinst;
    bit m_busy, m_stale, m_have, m_fault, mp, zero_mode;
    int mc;
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic bit m_mis();
`ifdef IFU_MISALIGN_TRAP_EN
        return m_pc[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction
    function automatic logic [W-1:0] tgt(input logic [W-1:0] a);
`ifdef IFU_MISALIGN_TRAP_EN
        return a;
`else
        return {a[W-1:2], 2'b00};
`endif
    endfunction
    function automatic bit m_req();
        return !m_busy && !m_have && !m_mis();
    endfunction
    function automatic logic [31:0] memfn(input logic [W-1:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
    endfunction
    task automatic step(input bit r, input bit rv, input logic [W-1:0] rpc, input bit rdy, input bit orr);
        bit acc, resp;
        logic [W-1:0] a;
        logic [31:0] d;
        @(negedge clk);
        chk("req_valid", W'(bus.imem_req_valid), W'(m_req()));
        if (m_req()) chk("req_addr", bus.imem_req_addr, m_pc);
        chk("out_valid", W'(bus.out_valid), W'(m_have));
        chk("out_pc", bus.out_pc, m_opc);
        chk("out_inst", W'(bus.out_inst), W'(m_oinst));
        chk("out_fault", W'(bus.out_fault), W'(m_fault));
        rst = r;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.imem_req_ready = rdy;
        bus.out_ready = orr;
        resp = mp && mc == 0;
        d = zero_mode ? 32'h0000_0013 : memfn(ma);
        bus.imem_resp_valid = resp;
        bus.imem_resp_data = resp ? d : $urandom();
        acc = m_req() && rdy;
        a = m_pc;
        @(posedge clk);
        if (r) begin
            m_pc = RST_PC; m_busy = 0; m_stale = 0; m_have = 0; m_fault = 0;
            m_opc = '0; m_oinst = '0; mp = 0;
        end else begin
            if (rv) begin
                m_pc = tgt(rpc); m_have = 0; m_fault = 0;
                m_stale = (m_busy && !resp) || acc;
                m_busy = m_stale;
            end else if (!m_busy && !m_have) begin
                if (m_mis()) begin
                    m_have = 1; m_fault = 1; m_opc = m_pc; m_oinst = 0;
                end else if (acc) m_busy = 1;
            end else if (m_busy && resp) begin
                m_busy = 0;
                if (m_stale) m_stale = 0;
                else begin
                    m_have = 1; m_fault = 0; m_opc = m_pc; m_oinst = d; m_pc = m_pc + 64'd4;
                end
            end else if (m_have && orr) begin
                m_have = 0; m_fault = 0;
            end
            if (resp) mp = 0;
            else if (mp && mc > 0) mc--;
            if (acc) begin
                mp = 1; ma = a; mc = zero_mode ? 0 : $urandom_range(0, 3);
            end
        end
    endtask
    initial begin
        rst = 1'b1;
        bus.redirect_valid = 0; bus.redirect_pc = '0; bus.imem_req_ready = 0;
        bus.imem_resp_valid = 0; bus.imem_resp_data = '0; bus.out_ready = 0;
        zero_mode = 1; mp = 0; mc = 0; ma = '0;
        @(posedge clk);
        #1;
        m_pc = RST_PC; m_busy = 0; m_stale = 0; m_have = 0; m_fault = 0; m_opc = '0; m_oinst = '0;
        step(1, 0, '0, 1, 1);
        for (int i = 0; i < 12; i++) step(0, 0, '0, 1, 1);
        zero_mode = 0;
        for (int i = 0; i < 10; i++) step(0, 0, '0, 1'($urandom_range(0, 1)), 0);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 1, 1);
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1);
        for (int i = 0; i < 14; i++) step(0, 0, '0, 1, 1);
        step(0, 1, 64'h0000_0000_8000_0102, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 1);
        for (int i = 0; i < 4000; i++) begin
            logic [W-1:0] rpc;
            int k;
            k = $urandom_range(0, 3);
            rpc = k == 0 ? 64'hFFFF_FFFF_FFFF_FFFC : k == 1 ? 64'h0000_0000_8000_0102 :
                  k == 2 ? (RST_PC + 64'($urandom_range(0, 255) * 4)) : {32'($urandom()), 32'($urandom())};
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, rpc,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
        end
        step(0, 0, '0, 1, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
